// File: rtl/cpu_datapath_core.sv
// Storage and sequencing datapath of the 16-bit processor: register file with ALU and flags,
// data RAM, program counter and the shared read-data mux.
module cpu_datapath_core #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  alu_read_enable,
  input  logic                  alu_write_enable,
  input  logic                  ram_read_enable,
  input  logic                  ram_write_enable,
  input  logic                  pc_read_enable,
  input  logic                  pc_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [3:0]            flags,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ram_rom_addr_link
);

  localparam int RG_W = $clog2(REG_COUNT);
  localparam int RA_W = $clog2(RAM_DEPTH);

  typedef struct packed {
    logic                  wr;
    logic                  upd;
    logic [DATA_WIDTH-1:0] res;
    logic [3:0]            flg;
  } alu_t;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] ram_q  [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]            flags_q;
  logic                  is_alu;
  logic                  cond;
  alu_t                  alu_r;
  logic [DATA_WIDTH-1:0] ram_rd;

  function automatic logic add_ovf(input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b,
                                   input logic signed [DATA_WIDTH-1:0] s);
    return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b,
                                   input logic signed [DATA_WIDTH-1:0] s);
    return (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction

  // Carry/borrow come from the extra MSB of a zero-extended add/subtract.
  function automatic alu_t alu_eval(input logic [3:0] fn,
                                    input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    alu_t                  r;
    logic [DATA_WIDTH:0]   sum, dif, inc, dec;
    logic [DATA_WIDTH-1:0] one;
    logic                  c, v;
    one = DATA_WIDTH'(1);
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    inc = {1'b0, a} + {1'b0, one};
    dec = {1'b0, a} - {1'b0, one};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fn)
      4'h0: begin r.res = sum[DATA_WIDTH-1:0]; c = sum[DATA_WIDTH]; v = add_ovf(a, b, r.res); end
      4'h1,
      4'h7: begin r.res = dif[DATA_WIDTH-1:0]; c = dif[DATA_WIDTH]; v = sub_ovf(a, b, r.res); end
      4'h2: r.res = a & b;
      4'h3: r.res = a | b;
      4'h4: r.res = a ^ b;
      4'h5: begin r.res = {a[DATA_WIDTH-2:0], 1'b0}; c = a[DATA_WIDTH-1]; end
      4'h6: begin r.res = {1'b0, a[DATA_WIDTH-1:1]}; c = a[0]; end
      4'h8: begin r.res = inc[DATA_WIDTH-1:0]; c = inc[DATA_WIDTH]; v = add_ovf(a, one, r.res); end
      4'h9: begin r.res = dec[DATA_WIDTH-1:0]; c = dec[DATA_WIDTH]; v = sub_ovf(a, one, r.res); end
      default: ;
    endcase
    r.upd = (fn <= 4'h9);
    r.wr  = r.upd && (fn != 4'h7);
    r.flg = {v, r.res[DATA_WIDTH-1], c, (r.res == '0)};
    return r;
  endfunction

  assign is_alu = (opcode[15:12] == 4'b0001);
  assign alu_r  = alu_eval(opcode[11:8], regs_q[opcode[4 +: RG_W]], regs_q[opcode[0 +: RG_W]]);
  assign ram_rd = ram_q[opcode[RA_W-1:0]];

  // Branch conditions look at the flags as they stand before the edge.
  always_comb begin
    case (opcode[11:8])
      4'h0:    cond = 1'b1;
      4'h1:    cond = flags_q[0];
      4'h2:    cond = !flags_q[0];
      4'h3:    cond = flags_q[1];
      4'h4:    cond = !flags_q[1];
      4'h5:    cond = flags_q[2];
      default: cond = 1'b0;
    endcase
    pc_d = pc_q + DATA_WIDTH'(1);
    if (cond && opcode[15:12] == 4'h7)      pc_d = ram_rd;
    else if (cond && opcode[15:12] == 4'hF) pc_d = operand;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      flags_q <= '0;
      pc_q    <= '0;
    end else begin
      if (pc_enable) pc_q <= pc_d;
      if (alu_write_enable) begin
        if (is_alu) begin
          if (alu_r.upd) flags_q <= alu_r.flg;
          if (alu_r.wr)  regs_q[operand[RG_W-1:0]] <= alu_r.res;
        end else begin
          regs_q[operand[RG_W-1:0]] <= data_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else if (ram_write_enable) begin
      ram_q[operand[RA_W-1:0]] <= data_in;
    end
  end

  always_comb begin
    data_out_valid = pc_read_enable | alu_read_enable | ram_read_enable;
    if (pc_read_enable)       data_out = pc_q;
    else if (alu_read_enable) data_out = regs_q[opcode[0 +: RG_W]];
    else if (ram_read_enable) data_out = ram_rd;
    else                      data_out = '0;
  end

  assign flags             = flags_q;
  assign pc                = pc_q;
  assign ram_rom_addr_link = ram_rd;

endmodule

// File: tb/tb_cpu_datapath_core.sv
// Directed and randomized bench for cpu_datapath_core against an arithmetic reference model.
module tb_cpu_datapath_core;

  logic        clk, reset;
  logic [15:0] opcode, operand, data_in;
  logic        alu_read_enable, alu_write_enable, ram_read_enable, ram_write_enable;
  logic        pc_read_enable, pc_enable;
  logic [15:0] data_out, pc, ram_rom_addr_link;
  logic        data_out_valid;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  int mreg [16];
  int mram [256];
  int mpc;
  bit mz, mc, mn, mv;
  logic [15:0] obs_do;
  logic        obs_vld;

  cpu_datapath_core dut (
    .clk(clk), .reset(reset), .opcode(opcode), .operand(operand), .data_in(data_in),
    .alu_read_enable(alu_read_enable), .alu_write_enable(alu_write_enable),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .pc_read_enable(pc_read_enable), .pc_enable(pc_enable),
    .data_out(data_out), .data_out_valid(data_out_valid), .flags(flags), .pc(pc),
    .ram_rom_addr_link(ram_rom_addr_link)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = 0;
    foreach (mram[i]) mram[i] = 0;
    mpc = 0; mz = 0; mc = 0; mn = 0; mv = 0;
  endtask

  function automatic int m_flags();
    return {mv, mn, mc, mz};
  endfunction

  function automatic int m_dout();
    if (pc_read_enable)  return mpc;
    if (alu_read_enable) return mreg[opcode & 15];
    if (ram_read_enable) return mram[opcode & 255];
    return 0;
  endfunction

  task automatic model_edge();
    int op, opd, top, fn, a, b, res, npc;
    bit cnd, nc, nv, upd, wr;
    op = opcode; opd = operand; top = op >> 12; fn = (op >> 8) & 15;
    npc = mpc;
    if (pc_enable) begin
      case (fn)
        0: cnd = 1;  1: cnd = mz;  2: cnd = !mz;
        3: cnd = mc; 4: cnd = !mc; 5: cnd = mn;
        default: cnd = 0;
      endcase
      if (top == 7 && cnd)       npc = mram[op & 255];
      else if (top == 15 && cnd) npc = opd;
      else                       npc = (mpc + 1) % 65536;
    end
    if (alu_write_enable) begin
      if (top == 1) begin
        a = mreg[(op >> 4) & 15]; b = mreg[op & 15];
        upd = 1; wr = (fn != 7); nc = 0; nv = 0; res = 0;
        case (fn)
          0: begin res = (a + b) % 65536; nc = (a + b) > 65535; nv = ovf(sx(a) + sx(b)); end
          1, 7: begin res = (a - b + 65536) % 65536; nc = a < b; nv = ovf(sx(a) - sx(b)); end
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          5: begin res = (a * 2) % 65536; nc = a >= 32768; end
          6: begin res = a / 2; nc = a % 2; end
          8: begin res = (a + 1) % 65536; nc = a == 65535; nv = ovf(sx(a) + 1); end
          9: begin res = (a + 65535) % 65536; nc = a == 0; nv = ovf(sx(a) - 1); end
          default: begin upd = 0; wr = 0; end
        endcase
        if (upd) begin mz = (res == 0); mn = (res >= 32768); mc = nc; mv = nv; end
        if (wr) mreg[opd & 15] = res;
      end else begin
        mreg[opd & 15] = data_in;
      end
    end
    if (ram_write_enable) mram[opd & 255] = data_in;
    mpc = npc;
  endtask

  // en = {pc_re, alu_re, ram_re, pc_en, alu_we, ram_we}
  task automatic cyc(input logic [15:0] op, input logic [15:0] opd, input logic [15:0] din,
                     input logic [5:0] en);
    opcode = op; operand = opd; data_in = din;
    {pc_read_enable, alu_read_enable, ram_read_enable, pc_enable, alu_write_enable,
     ram_write_enable} = en;
    #1;
    obs_do = data_out; obs_vld = data_out_valid;
    chk("data_out", data_out, m_dout());
    chk("data_out_valid", data_out_valid, (en[5:3] != 0));
    chk("ram_link", ram_rom_addr_link, mram[op & 255]);
    model_edge();
    @(posedge clk); #1;
    chk("pc", pc, mpc);
    chk("flags", flags, m_flags());
  endtask

  initial begin
    reset = 1'b0;
    {opcode, operand, data_in} = '0;
    {pc_read_enable, alu_read_enable, ram_read_enable, pc_enable, alu_write_enable,
     ram_write_enable} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_dout", data_out, 0);

    repeat (3) cyc(16'h2200, 16'h0, 16'h0, 6'b000100);
    chk("pc_after_3", pc, 16'h0003);

    opcode = 16'h2200; pc_read_enable = 1'b1; pc_enable = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_pc", pc, 0);
    chk("async_rst_flags", flags, 0);
    chk("async_rst_dout", data_out, 0);
    #2 reset = 1'b1;
    pc_read_enable = 1'b0; pc_enable = 1'b0;
    @(posedge clk); #1;

    cyc(16'h4100, 16'h0005, 16'h1234, 6'b000001);
    cyc(16'h4205, 16'h0000, 16'h0000, 6'b001000);
    chk("ram_read", obs_do, 16'h1234);
    chk("ram_read_vld", obs_vld, 1'b1);

    cyc(16'h9200, 16'h0001, 16'hFFFF, 6'b000010);
    cyc(16'h9200, 16'h0002, 16'h0001, 6'b000010);
    cyc(16'h1012, 16'h0003, 16'h0000, 6'b000010);
    chk("add_wrap_flags", flags, 4'b0011);
    cyc(16'h2203, 16'h0000, 16'h0000, 6'b010000);
    chk("add_wrap_r3", obs_do, 16'h0000);

    cyc(16'h9200, 16'h0001, 16'h7FFF, 6'b000010);
    cyc(16'h1012, 16'h0003, 16'h0000, 6'b000010);
    chk("add_ovf_flags", flags, 4'b1100);
    cyc(16'h1712, 16'h0003, 16'h0000, 6'b000010);
    chk("cmp_flags", flags, 4'b0000);
    cyc(16'h2203, 16'h0000, 16'h0000, 6'b010000);
    chk("cmp_no_write", obs_do, 16'h8000);

    cyc(16'h0000, 16'h0010, 16'h0040, 6'b000001);
    cyc(16'h7010, 16'h0000, 16'h0000, 6'b000100);
    chk("jmp_ram", pc, 16'h0040);
    cyc(16'hF100, 16'h0200, 16'h0000, 6'b000100);
    chk("jz_not_taken", pc, 16'h0041);
    cyc(16'h1411, 16'h0004, 16'h0000, 6'b000010);
    cyc(16'hF100, 16'h0200, 16'h0000, 6'b000100);
    chk("jz_taken", pc, 16'h0200);

    cyc(16'hF000, 16'hFFFF, 16'h0000, 6'b000100);
    cyc(16'h2200, 16'h0000, 16'h0000, 6'b000100);
    chk("pc_wrap", pc, 16'h0000);
    cyc(16'h2200, 16'h0000, 16'h0000, 6'b000100);
    cyc(16'h2210, 16'h0000, 16'h0000, 6'b101000);
    chk("pc_priority", obs_do, 16'h0001);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] op;
      logic [3:0]  cls;
      op = 16'($urandom);
      case ($urandom_range(0, 3))
        0: cls = 4'h1;
        1: cls = 4'h7;
        2: cls = 4'hF;
        default: cls = op[15:12];
      endcase
      op[15:12] = cls;
      if (cls == 4'h1) op[11:8] = 4'($urandom_range(0, 10));
      cyc(op, 16'($urandom), 16'($urandom), 6'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath_core.md
Name: cpu_datapath_core

Overview:
- Storage and sequencing datapath of the 16-bit fetch-decode-execute processor.
- Contains three parts:
  - a 16-entry register file with an ALU and a flags register;
  - a 256-word data RAM;
  - the program counter.
- The external FSM drives opcode/operand words from ROM and the per-cycle enables.
- All shared-bus traffic goes through one data_in port and one muxed data_out port.

Parameters:
- DATA_WIDTH, 16, word width; the carry bit is result bit DATA_WIDTH.
- REG_COUNT, 16, number of ALU registers; addressed by 4 bits.
- RAM_DEPTH, 256, number of RAM words; addressed by 8 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  16  current instruction opcode word
- operand  in  16  current instruction operand word
- data_in  in  16  bus write data (immediate, ROM data or external value)
- alu_read_enable  in  1  drive register[opcode[3:0]] onto data_out
- alu_write_enable  in  1  ALU execute or register load at the clock edge
- ram_read_enable  in  1  drive ram[opcode[7:0]] onto data_out
- ram_write_enable  in  1  write RAM at the clock edge
- pc_read_enable  in  1  drive pc onto data_out
- pc_enable  in  1  advance or jump the PC at the clock edge
- data_out  out  16  muxed read data
- data_out_valid  out  1  high when any read enable is high
- flags  out  4  {V,N,C,Z} = bits [3:2:1:0]
- pc  out  16  program counter
- ram_rom_addr_link  out  16  ram[opcode[7:0]], combinational, always valid

Behaviour:
- Reset (reset=0, asynchronous): all registers, all RAM words, flags and pc clear to 0.
- data_out and data_out_valid are combinational:
  - priority pc_read > alu_read > ram_read;
  - when no read enable is high, data_out=0 and data_out_valid=0.
- RAM:
  - Read is combinational: ram[opcode[7:0]].
  - Write on clock edge when ram_write_enable: ram[operand[7:0]] <= data_in.
  - A read and write in the same cycle returns the old value; the new value is visible next cycle.
- Register file, when alu_write_enable at the clock edge:
  - If opcode[15:12]=4'b0001 (ALU op): A=reg[opcode[7:4]], B=reg[opcode[3:0]], dest=operand[3:0], function=opcode[11:8].
  - Otherwise (load): reg[operand[3:0]] <= data_in; flags unchanged.
- ALU functions (result written to dest, flags updated):
  - 0 ADD: C = bit16 of the 17-bit sum; V = signed overflow.
  - 1 SUB A-B: C = borrow (A<B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 SHL by 1: C=A[15].
  - 6 SHR by 1, logical: C=A[0].
  - 7 CMP: same flags as SUB, dest not written.
  - 8 INC A: C and V as for ADD.
  - 9 DEC A: C and V as for SUB.
  - A–F: no write, flags unchanged.
  - All arithmetic is mod 2^16.
  - Z = result==0; N = result[15]. For CMP, Z and N come from the difference.
  - V = 0 for logic ops and shifts.
- PC, updated only when pc_enable at the clock edge:
  - Condition code opcode[11:8]: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, other never.
  - opcode[15:12]=7: if the condition holds, pc <= ram[opcode[7:0]]; else pc <= pc+1.
  - opcode[15:12]=F: if the condition holds, pc <= operand; else pc <= pc+1.
  - Any other opcode: pc <= pc+1; pc wraps from FFFF to 0000.
  - Conditions use the flags value before the edge.
- Simultaneous events:
  - An ALU write and a pc_enable in the same cycle are independent.
  - A jump sees the old flags.
  - A register write and alu_read of the same register in the same cycle reads the old value.
  - Reset asserted mid-operation overrides everything immediately.

Test Plan:
- Release reset, pulse pc_enable 3x with opcode=0x2200 -> pc=3; assert reset low -> pc=0, flags=0, data_out=0 immediately.
- data_in=0x1234, opcode=0x4100, operand=0x0005, ram_write_enable for one edge; then opcode=0x4205, ram_read_enable -> data_out=0x1234, data_out_valid=1.
- Load r1=0xFFFF and r2=0x0001 (opcode 0x9200, operand=1/2); then opcode=0x1012, operand=3, alu_write_enable -> r3=0, flags Z=1, C=1, V=0; read with opcode=0x2203 -> data_out=0.
- r1=0x7FFF, r2=1, ADD -> 0x8000, N=1, V=1, C=0; CMP opcode=0x1712 -> dest unchanged, C=0.
- ram[0x10]=0x0040, opcode=0x7010, pc_enable -> pc=0x0040; with Z=0, opcode=0xF100, operand=0x0200 -> pc=0x0041; with Z=1 -> pc=0x0200.
- pc=0xFFFF, pc_enable with opcode=0x2200 -> pc=0x0000; pc_read_enable and ram_read_enable both high -> data_out=pc.
